pla_prog_pipe: RTL and testbench

- Runtime-programmable, pipelined two-level AND-OR logic array; generalises the fixed 12-in/8-out combinational PLA blocks into a parametrised engine.
- The term table (input care/value masks plus output OR mask per product term) is loaded through a config port.
- Input vectors stream in over a valid/ready handshake and are evaluated in a 2-stage pipeline with full backpressure.
- Sits between input-vector producers and decision logic; one instance replaces many generated fixed-function PLAs.

---
 rtl/pla_prog_pipe.sv | 129 ++++++++++++
 tb/tb_pla_prog_pipe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pla_prog_pipe.sv
// Runtime-programmable AND-OR logic array with a 2-stage valid/ready pipeline.
// Optional output phase inversion is enabled with `define PLA_PHASE_INV_EN.
module pla_prog_pipe #(
   parameter int NUM_IN    = 12,
   parameter int NUM_OUT   = 8,
   parameter int NUM_TERMS = 32,
   parameter int AW        = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   output logic               cfg_ready,
   input  logic [AW-1:0]      cfg_addr,
   input  logic [NUM_IN-1:0]  cfg_care,
   input  logic [NUM_IN-1:0]  cfg_val,
   input  logic [NUM_OUT-1:0] cfg_or,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [NUM_IN-1:0]  x,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NUM_OUT-1:0] z
`ifdef PLA_PHASE_INV_EN
   ,
   input  logic               cfg_inv_we,
   input  logic [NUM_OUT-1:0] cfg_inv
`endif
);

   // Handshake: a beat transfers on a rising edge where valid && ready are both
   // high; the producer may drop valid at any time, the consumer may not drop
   // out_valid or change z until out_ready has accepted the beat.

   localparam logic [AW:0] LP_TERMS = (AW+1)'(NUM_TERMS);

   logic [NUM_IN-1:0]    r_care [NUM_TERMS];
   logic [NUM_IN-1:0]    r_val  [NUM_TERMS];
   logic [NUM_OUT-1:0]   r_or   [NUM_TERMS];

   logic                 r_s1_valid;
   logic [NUM_TERMS-1:0] r_s1_hit;
   logic                 r_s2_valid;
   logic [NUM_OUT-1:0]   r_z;

   logic                 w_stall;
   logic                 w_in_fire;
   logic                 w_cfg_fire;
   logic                 w_addr_ok;
   logic [NUM_TERMS-1:0] w_hit;
   logic [NUM_OUT-1:0]   w_or_res;
   logic [NUM_OUT-1:0]   w_z_next;

   assign w_stall    = r_s2_valid && !out_ready;
   assign cfg_ready  = !r_s1_valid && !r_s2_valid;
   assign in_ready   = !w_stall && !cfg_we && !rst;
   assign w_in_fire  = in_valid && in_ready;
   assign w_addr_ok  = {1'b0, cfg_addr} < LP_TERMS;
   assign w_cfg_fire = cfg_we && cfg_ready && w_addr_ok;

   assign out_valid  = r_s2_valid;
   assign z          = r_z;

   // AND plane: evaluated on the incoming vector so S1 only stores the hits.
   always_comb begin
      w_hit = '0;
      for (int t = 0; t < NUM_TERMS; t++) begin
         w_hit[t] = ((x ^ r_val[t]) & r_care[t]) == '0;
      end
   end

   always_comb begin
      w_or_res = '0;
      for (int t = 0; t < NUM_TERMS; t++) begin
         if (r_s1_hit[t]) begin
            w_or_res = w_or_res | r_or[t];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int t = 0; t < NUM_TERMS; t++) begin
            r_care[t] <= '0;
            r_val[t]  <= '0;
            r_or[t]   <= '0;
         end
      end else if (w_cfg_fire) begin
         r_care[cfg_addr] <= cfg_care;
         r_val[cfg_addr]  <= cfg_val;
         r_or[cfg_addr]   <= cfg_or;
      end
   end

`ifdef PLA_PHASE_INV_EN
   logic [NUM_OUT-1:0] r_inv;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_inv <= '0;
      end else if (cfg_inv_we && cfg_ready) begin
         r_inv <= cfg_inv;
      end
   end

   assign w_z_next = w_or_res ^ r_inv;
`else
   assign w_z_next = w_or_res;
`endif

   // Both stages move together; a stall freezes everything so z stays stable.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_hit   <= '0;
         r_s2_valid <= 1'b0;
         r_z        <= '0;
      end else if (!w_stall) begin
         r_s1_valid <= w_in_fire;
         if (w_in_fire) begin
            r_s1_hit <= w_hit;
         end
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_z <= w_z_next;
         end
      end
   end

endmodule

// File: tb/tb_pla_prog_pipe.sv
// Directed self-checking bench for pla_prog_pipe (default 12-in/8-out/32-term).
module tb_pla_prog_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_we = 1'b0;
   logic        cfg_ready;
   logic [4:0]  cfg_addr = '0;
   logic [11:0] cfg_care = '0;
   logic [11:0] cfg_val = '0;
   logic [7:0]  cfg_or = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [11:0] x = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  z;
`ifdef PLA_PHASE_INV_EN
   logic        cfg_inv_we = 1'b0;
   logic [7:0]  cfg_inv = '0;
`endif

   int          total = 0;
   int          bad = 0;
   int          n_pushed = 0;
   int          n_seen = 0;
   logic [7:0]  exp_q[$];
   bit          held_valid = 0;
   logic [7:0]  held_z = '0;

   pla_prog_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we),
      .cfg_ready (cfg_ready),
      .cfg_addr  (cfg_addr),
      .cfg_care  (cfg_care),
      .cfg_val   (cfg_val),
      .cfg_or    (cfg_or),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z         (z)
`ifdef PLA_PHASE_INV_EN
      ,
      .cfg_inv_we(cfg_inv_we),
      .cfg_inv   (cfg_inv)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every accepted result is popped in order; held z checked on stalls.
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         held_valid = 0;
         n_seen++;
         if (exp_q.size() == 0) begin
            check("extra_out", {24'h0, z}, 32'hFFFF_FFFF);
         end else begin
            check("z_order", {24'h0, z}, {24'h0, exp_q.pop_front()});
         end
      end else if (out_valid && !out_ready) begin
         if (held_valid) check("z_held", {24'h0, z}, {24'h0, held_z});
         held_valid = 1;
         held_z = z;
      end else begin
         held_valid = 0;
      end
   end

   task automatic send(input logic [11:0] xv, input logic [7:0] zexp, input bit push);
      bit done = 0;
      in_valid = 1'b1;
      x = xv;
      for (int i = 0; i < 20 && !done; i++) begin
         #1;
         if (in_ready) begin
            if (push) begin
               exp_q.push_back(zexp);
               n_pushed++;
            end
            done = 1;
         end
         tick();
      end
      if (!done) begin
         check("send_timeout", 0, 1);
         in_valid = 1'b0;
      end
   endtask

   task automatic cfg_write(input logic [4:0] a, input logic [11:0] c, input logic [11:0] v,
                            input logic [7:0] o);
      bit done = 0;
      cfg_we = 1'b1;
      cfg_addr = a;
      cfg_care = c;
      cfg_val = v;
      cfg_or = o;
      for (int i = 0; i < 30 && !done; i++) begin
         #1;
         if (cfg_ready) done = 1;
         tick();
      end
      cfg_we = 1'b0;
      if (!done) check("cfg_timeout", 0, 1);
   endtask

   task automatic drain();
      in_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (exp_q.size() == 0 && cfg_ready) break;
         tick();
      end
      check("drain_q", exp_q.size(), 0);
      check("drain_cfg_rdy", {31'h0, cfg_ready}, 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      cfg_we = 1'b0;
      tick();
      tick();
      check("rst_out_valid", {31'h0, out_valid}, 0);
      check("rst_z", {24'h0, z}, 0);
      check("rst_in_ready", {31'h0, in_ready}, 0);
      check("rst_cfg_ready", {31'h0, cfg_ready}, 1);
      rst = 1'b0;
      #1;
      check("rdy_after_rst", {31'h0, in_ready}, 1);
   endtask

   initial begin
      tick();
      do_reset();

      // cleared table -> z=0, latency 2
      send(12'hFFF, 8'h00, 1);
      in_valid = 1'b0;
      check("lat_s1_out_valid", {31'h0, out_valid}, 0);
      check("lat_s1_cfg_busy", {31'h0, cfg_ready}, 0);
      tick();
      check("lat_out_valid", {31'h0, out_valid}, 1);
      check("clear_z", {24'h0, z}, 0);
      tick();
      check("bubble_valid", {31'h0, out_valid}, 0);
      check("cfg_rdy_drained", {31'h0, cfg_ready}, 1);

      // single term, back-to-back stream
      cfg_write(5'd0, 12'h014, 12'h010, 8'h01);
      send(12'h010, 8'h01, 1);
      send(12'h014, 8'h00, 1);
      check("stream_first_valid", {31'h0, out_valid}, 1);
      check("stream_first_z", {24'h0, z}, 8'h01);
      send(12'h000, 8'h00, 1);
      drain();

      // two terms OR-ed together
      cfg_write(5'd0, 12'h001, 12'h001, 8'h03);
      cfg_write(5'd5, 12'h002, 12'h000, 8'h06);
      send(12'h001, 8'h07, 1);
      send(12'h003, 8'h03, 1);
      send(12'h002, 8'h00, 1);
      drain();

      // backpressure: 4 vectors, output stalled 3 cycles
      out_ready = 1'b0;
      send(12'h001, 8'h07, 1);
      send(12'h003, 8'h03, 1);
      in_valid = 1'b1;
      x = 12'h002;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("stall_in_ready", {31'h0, in_ready}, 0);
         check("stall_z", {24'h0, z}, 8'h07);
         tick();
      end
      out_ready = 1'b1;
      send(12'h002, 8'h00, 1);
      send(12'h000, 8'h06, 1);
      drain();

      // config request while 2 vectors in flight
      send(12'h001, 8'h07, 1);
      send(12'h002, 8'h00, 1);
      in_valid = 1'b0;
      cfg_we = 1'b1;
      cfg_addr = 5'd7;
      cfg_care = 12'h000;
      cfg_val = 12'h000;
      cfg_or = 8'h10;
      #1;
      check("cfg_busy_inflight", {31'h0, cfg_ready}, 0);
      cfg_write(5'd7, 12'h000, 12'h000, 8'h10);
      check("cfg_after_deliver", exp_q.size(), 0);
      send(12'h001, 8'h17, 1);
      send(12'h000, 8'h16, 1);
      drain();

      // cfg_we and in_valid together: config wins
      cfg_we = 1'b1;
      cfg_addr = 5'd9;
      cfg_care = 12'h800;
      cfg_val = 12'h800;
      cfg_or = 8'h20;
      in_valid = 1'b1;
      x = 12'h800;
      #1;
      check("cfg_vs_in_ready", {31'h0, in_ready}, 0);
      tick();
      cfg_we = 1'b0;
      send(12'h800, 8'h36, 1);
      drain();

`ifdef PLA_PHASE_INV_EN
      // output phase inversion on a cleared table
      do_reset();
      cfg_inv_we = 1'b1;
      cfg_inv = 8'h80;
      tick();
      cfg_inv_we = 1'b0;
      send(12'h123, 8'h80, 1);
      send(12'hABC, 8'h80, 1);
      drain();
`endif

      // reset mid-stream discards in-flight vectors
      out_ready = 1'b0;
      send(12'h001, 8'h00, 0);
      send(12'h002, 8'h00, 0);
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("post_rst_no_out", {31'h0, out_valid}, 0);
         tick();
      end
      send(12'h5A5, 8'h00, 1);
      drain();

      check("count_seen", n_seen, n_pushed);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
